// File: rtl/ex_branch_unit.sv
// ============================================================================
// Module      : ex_branch_unit
// Description : EX-stage control-transfer resolver: owns icc, resolves
//               Bicc/CALL/JMPL and drives redirect, ID flush and slot annul.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_branch_unit #(
    parameter int PC_SIZE   = 32,
    parameter int INST_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ex_valid,
    input  logic [1:0]           ex_op,
    input  logic [2:0]           ex_op2,
    input  logic [5:0]           ex_op3,
    input  logic [3:0]           ex_cond,
    input  logic                 ex_a,
    input  logic [21:0]          ex_disp22,
    input  logic [29:0]          ex_disp30,
    input  logic [PC_SIZE-1:0]   ex_PCplus4,
    input  logic [INST_SIZE-1:0] ex_alu_result,
    input  logic [3:0]           ex_alu_icc,
    output logic                 redirect_valid,
    output logic [PC_SIZE-1:0]   redirect_pc,
    output logic                 flush_id,
    output logic                 kill_ex,
    output logic [3:0]           icc_out
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        SLOT       = 2'd1,
        SLOT_ANNUL = 2'd2
    } state_t;

    localparam logic [5:0] c_OP3_JMPL = 6'b111000;
    localparam logic [3:0] c_COND_BA  = 4'b1000;

    state_t               state_q, state_d;
    logic [3:0]           icc_q;
    logic                 redirect_valid_q;
    logic [PC_SIZE-1:0]   redirect_pc_q;
    logic                 flush_id_q;
    logic                 kill_ex_q;

    logic                 w_live;
    logic                 w_is_bicc, w_is_call, w_is_jmpl, w_is_cc, w_is_cti;
    logic                 w_cond_true, w_taken, w_annul;
    logic [PC_SIZE-1:0]   w_pc, w_target;
    logic [PC_SIZE-1:0]   w_bicc_off, w_call_off;

    assign w_live    = ex_valid && (state_q != SLOT_ANNUL);
    assign w_is_bicc = (ex_op == 2'b00) && (ex_op2 == 3'b010);
    assign w_is_call = (ex_op == 2'b01);
    assign w_is_jmpl = (ex_op == 2'b10) && (ex_op3 == c_OP3_JMPL);
    assign w_is_cc   = (ex_op == 2'b10) && !ex_op3[5] && ex_op3[4];
    assign w_is_cti  = w_is_bicc || w_is_call || w_is_jmpl;

    // Lower three bits pick the base test; cond[3] inverts it.
    always_comb begin
        w_cond_true = 1'b0;
        case (ex_cond[2:0])
            3'd0: w_cond_true = 1'b0;
            3'd1: w_cond_true = icc_q[2];
            3'd2: w_cond_true = icc_q[2] | (icc_q[3] ^ icc_q[1]);
            3'd3: w_cond_true = icc_q[3] ^ icc_q[1];
            3'd4: w_cond_true = icc_q[0] | icc_q[2];
            3'd5: w_cond_true = icc_q[0];
            3'd6: w_cond_true = icc_q[3];
            3'd7: w_cond_true = icc_q[1];
            default: w_cond_true = 1'b0;
        endcase
        w_cond_true = w_cond_true ^ ex_cond[3];
    end

    assign w_taken = w_is_call || w_is_jmpl || (w_is_bicc && w_cond_true);
    assign w_annul = w_is_bicc && ex_a && (!w_cond_true || (ex_cond == c_COND_BA));

    assign w_pc       = ex_PCplus4 - PC_SIZE'(4);
    assign w_bicc_off = {{(PC_SIZE-24){ex_disp22[21]}}, ex_disp22, 2'b00};
    assign w_call_off = PC_SIZE'({ex_disp30, 2'b00});

    always_comb begin
        w_target = PC_SIZE'(ex_alu_result);
        if (w_is_bicc)
            w_target = w_pc + w_bicc_off;
        else if (w_is_call)
            w_target = w_pc + w_call_off;
    end

    // A bubble freezes the machine so the delay slot is still recognised.
    always_comb begin
        state_d = state_q;
        if (ex_valid) begin
            if (state_q == SLOT_ANNUL)
                state_d = RUN;
            else if (w_is_cti)
                state_d = w_annul ? SLOT_ANNUL : SLOT;
            else
                state_d = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= RUN;
            icc_q            <= 4'd0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            flush_id_q       <= 1'b0;
            kill_ex_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            redirect_valid_q <= w_live && w_is_cti && w_taken;
            flush_id_q       <= w_live && w_is_cti && w_taken;
            kill_ex_q        <= (state_d == SLOT_ANNUL);
            if (w_live && w_is_cc)
                icc_q <= ex_alu_icc;
            if (w_live && w_is_cti && w_taken)
                redirect_pc_q <= w_target;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush_id       = flush_id_q;
    assign kill_ex        = kill_ex_q;
    assign icc_out        = icc_q;

endmodule

`default_nettype wire

// File: tb/tb_ex_branch_unit.sv
// ============================================================================
// Module      : tb_ex_branch_unit
// Description : Directed self-checking bench for ex_branch_unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_branch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic [1:0]  ex_op;
    logic [2:0]  ex_op2;
    logic [5:0]  ex_op3;
    logic [3:0]  ex_cond;
    logic        ex_a;
    logic [21:0] ex_disp22;
    logic [29:0] ex_disp30;
    logic [31:0] ex_PCplus4;
    logic [31:0] ex_alu_result;
    logic [3:0]  ex_alu_icc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush_id;
    logic        kill_ex;
    logic [3:0]  icc_out;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    ex_branch_unit #(.PC_SIZE(32), .INST_SIZE(32)) u_dut (
        .clk            (clk),
        .reset          (reset),
        .ex_valid       (ex_valid),
        .ex_op          (ex_op),
        .ex_op2         (ex_op2),
        .ex_op3         (ex_op3),
        .ex_cond        (ex_cond),
        .ex_a           (ex_a),
        .ex_disp22      (ex_disp22),
        .ex_disp30      (ex_disp30),
        .ex_PCplus4     (ex_PCplus4),
        .ex_alu_result  (ex_alu_result),
        .ex_alu_icc     (ex_alu_icc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush_id       (flush_id),
        .kill_ex        (kill_ex),
        .icc_out        (icc_out)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outs(input string tag, input logic rv, input logic [31:0] pc,
                            input logic fl, input logic kl);
        chk({tag, ".rv"},    {31'd0, redirect_valid}, {31'd0, rv});
        chk({tag, ".pc"},    redirect_pc, pc);
        chk({tag, ".flush"}, {31'd0, flush_id}, {31'd0, fl});
        chk({tag, ".kill"},  {31'd0, kill_ex}, {31'd0, kl});
    endtask

    task automatic drv_alu(input logic [5:0] op3, input logic [3:0] icc);
        ex_valid = 1'b1; ex_op = 2'b10; ex_op3 = op3; ex_alu_icc = icc; ex_op2 = 3'b000;
    endtask

    task automatic drv_bicc(input logic [3:0] cond, input logic a,
                            input logic [31:0] pc4, input logic [21:0] d22);
        ex_valid = 1'b1; ex_op = 2'b00; ex_op2 = 3'b010; ex_op3 = 6'd0;
        ex_cond = cond; ex_a = a; ex_PCplus4 = pc4; ex_disp22 = d22;
    endtask

    localparam logic [5:0] c_ADD   = 6'b000000;
    localparam logic [5:0] c_ADDCC = 6'b010000;
    localparam logic [5:0] c_SUBCC = 6'b010100;

    initial begin
        reset = 1'b1; ex_valid = 1'b0; ex_op = 2'b00; ex_op2 = 3'b000; ex_op3 = 6'd0;
        ex_cond = 4'd0; ex_a = 1'b0; ex_disp22 = 22'd0; ex_disp30 = 30'd0;
        ex_PCplus4 = 32'd0; ex_alu_result = 32'd0; ex_alu_icc = 4'd0;
        tick(); tick();
        chk_outs("reset", 1'b0, 32'd0, 1'b0, 1'b0);
        chk("reset.icc", {28'd0, icc_out}, 32'h0);
        reset = 1'b0;

        // subcc then BE taken: 0x100 + 0x40
        drv_alu(c_SUBCC, 4'b0100); tick();
        chk("subcc.icc", {28'd0, icc_out}, 32'h4);
        drv_bicc(4'b0001, 1'b0, 32'h104, 22'h10); tick();
        chk_outs("be", 1'b1, 32'h140, 1'b1, 1'b0);
        drv_alu(c_ADD, 4'b0000); tick();
        chk_outs("be_slot", 1'b0, 32'h140, 1'b0, 1'b0);

        // BNE,a untaken: slot addcc annulled, icc untouched
        drv_bicc(4'b1001, 1'b1, 32'h200, 22'h8); tick();
        chk_outs("bne_a", 1'b0, 32'h140, 1'b0, 1'b1);
        drv_alu(c_ADDCC, 4'b1000); tick();
        chk("bne_a.icc", {28'd0, icc_out}, 32'h4);
        chk("bne_a.kill_end", {31'd0, kill_ex}, 32'd0);

        // BA,a: 0x1C + 8, taken and annulling
        drv_bicc(4'b1000, 1'b1, 32'h20, 22'h2); tick();
        chk_outs("ba_a", 1'b1, 32'h24, 1'b1, 1'b1);
        drv_alu(c_ADDCC, 4'b0001); tick();
        chk_outs("ba_a_slot", 1'b0, 32'h24, 1'b0, 1'b0);
        chk("ba_a.icc", {28'd0, icc_out}, 32'h4);
        drv_alu(c_SUBCC, 4'b0001); tick();
        chk("run_again.icc", {28'd0, icc_out}, 32'h1);

        // CALL: 0x1000 + 0xFFFFFFFC
        ex_valid = 1'b1; ex_op = 2'b01; ex_PCplus4 = 32'h1004; ex_disp30 = 30'h3FFFFFFF; tick();
        chk_outs("call", 1'b1, 32'hFFC, 1'b1, 1'b0);
        drv_alu(c_ADD, 4'b0000); tick();

        // JMPL to ALU result
        ex_op3 = 6'b111000; ex_alu_result = 32'h2000; tick();
        chk_outs("jmpl", 1'b1, 32'h2000, 1'b1, 1'b0);
        drv_alu(c_ADD, 4'b0000); tick();

        // BA wrap-around: 0 + (-1 << 2)
        drv_bicc(4'b1000, 1'b0, 32'h4, 22'h3FFFFF); tick();
        chk_outs("ba_wrap", 1'b1, 32'hFFFFFFFC, 1'b1, 1'b0);
        drv_alu(c_ADD, 4'b0000); tick();

        // BVS with V=0, a=0: untaken, no annul
        drv_bicc(4'b0111, 1'b0, 32'h300, 22'h4); tick();
        chk_outs("bvs", 1'b0, 32'hFFFFFFFC, 1'b0, 1'b0);
        drv_alu(c_ADD, 4'b0000); tick();

        // BCS with C=1, a=1: taken, slot not annulled
        drv_bicc(4'b0101, 1'b1, 32'h400, 22'h1); tick();
        chk_outs("bcs_a", 1'b1, 32'h400, 1'b1, 1'b0);
        drv_alu(c_ADD, 4'b0000); tick();

        // Branch while ex_valid=0 is ignored
        drv_bicc(4'b1000, 1'b0, 32'h500, 22'h1); ex_valid = 1'b0; tick();
        chk("bubble.rv", {31'd0, redirect_valid}, 32'd0);

        // Taken branch, then reset during the redirect cycle
        drv_bicc(4'b1000, 1'b1, 32'h104, 22'h10); tick();
        chk("rst_mid.rv_pre", {31'd0, redirect_valid}, 32'd1);
        reset = 1'b1; drv_alu(c_ADDCC, 4'b1111); tick();
        chk_outs("rst_mid", 1'b0, 32'd0, 1'b0, 1'b0);
        chk("rst_mid.icc", {28'd0, icc_out}, 32'h0);
        reset = 1'b0; tick();
        chk("post_rst.icc", {28'd0, icc_out}, 32'hF);
        chk("post_rst.kill", {31'd0, kill_ex}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
